// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard-based forwarding, load-use stall, branch flush and freeze control.
module pipe_hazard_unit #(
    parameter int REG_W      = 5,
    parameter int N_SRC      = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_valid,
    input  logic [N_SRC*REG_W-1:0]   id_src,
    input  logic [N_SRC-1:0]         id_src_used,
    input  logic [REG_W-1:0]         id_dst,
    input  logic                     id_we,
    input  logic                     id_is_load,
    input  logic                     br_taken_e,
    input  logic                     mem_stall,
    output logic [N_SRC*SEL_W-1:0]   fwd_sel,
    output logic                     stall_fd,
    output logic                     freeze,
    output logic                     flush_d,
    output logic                     flush_e,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);
    logic [FWD_DEPTH:0]   v_q, v_d, we_q, we_d, ld_q, ld_d;
    logic [REG_W-1:0]     dst_q [FWD_DEPTH+1];
    logic [REG_W-1:0]     dst_d [FWD_DEPTH+1];
    logic [REG_W-1:0]     esrc_q [N_SRC];
    logic [REG_W-1:0]     esrc_d [N_SRC];
    logic [N_SRC-1:0]     eused_q, eused_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [N_SRC*SEL_W-1:0] fwd_c;
    logic                 lu, branch, stall_c, flush_e_c, take;
    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            logic hld;
            hld = 1'b0;
            for (int j = FWD_DEPTH; j >= 0; j--)
                if (v_q[j] && we_q[j] && dst_q[j] == id_src[i*REG_W +: REG_W])
                    hld = ld_q[j] && (j <= LOAD_STAGE - 2);
            if (id_src_used[i] && id_src[i*REG_W +: REG_W] != '0 && hld)
                lu = 1'b1;
        end
    end
    assign branch    = br_taken_e & ~mem_stall;
    assign flush_e_c = branch | (lu & ~mem_stall & id_valid);
    assign stall_c   = lu & id_valid & ~branch & ~mem_stall;
    assign take      = id_valid & ~flush_e_c;
    // smallest k wins because it is assigned last
    always_comb begin
        fwd_c = '0;
        for (int i = 0; i < N_SRC; i++)
            for (int k = FWD_DEPTH; k >= 1; k--)
                if (v_q[k] && we_q[k] && dst_q[k] == esrc_q[i] && dst_q[k] != '0 && eused_q[i] &&
                    (!ld_q[k] || k >= LOAD_STAGE))
                    fwd_c[i*SEL_W +: SEL_W] = SEL_W'(k);
    end
    always_comb begin
        v_d = v_q;
        we_d = we_q;
        ld_d = ld_q;
        dst_d = dst_q;
        esrc_d = esrc_q;
        eused_d = eused_q;
        if (!mem_stall) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                v_d[k] = v_q[k-1];
                we_d[k] = we_q[k-1];
                ld_d[k] = ld_q[k-1];
                dst_d[k] = dst_q[k-1];
            end
            v_d[0] = take;
            we_d[0] = take & id_we;
            ld_d[0] = take & id_is_load;
            dst_d[0] = id_dst;
            for (int i = 0; i < N_SRC; i++)
                esrc_d[i] = id_src[i*REG_W +: REG_W];
            eused_d = take ? id_src_used : '0;
        end
        stall_cnt_d = (stall_c && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (branch && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            we_q <= '0;
            ld_q <= '0;
            dst_q <= '{default: '0};
            esrc_q <= '{default: '0};
            eused_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            v_q <= v_d;
            we_q <= we_d;
            ld_q <= ld_d;
            dst_q <= dst_d;
            esrc_q <= esrc_d;
            eused_q <= eused_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign fwd_sel   = rst_n ? fwd_c : '0;
    assign stall_fd  = rst_n & stall_c;
    assign freeze    = rst_n & mem_stall;
    assign flush_d   = rst_n & branch;
    assign flush_e   = rst_n & flush_e_c;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed checks of forwarding, stalls, flushes, freeze and reset.
module tb_pipe_hazard_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, id_we, id_is_load, br_taken_e, mem_stall;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  id_dst;
    logic [3:0]  fwd_sel, l_fwd_sel;
    logic        stall_fd, freeze, flush_d, flush_e;
    logic        l_stall_fd, l_freeze, l_flush_d, l_flush_e;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  l_stall_cnt, l_flush_cnt;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_dst(id_dst), .id_we(id_we), .id_is_load(id_is_load), .br_taken_e(br_taken_e),
        .mem_stall(mem_stall), .fwd_sel(fwd_sel), .stall_fd(stall_fd), .freeze(freeze),
        .flush_d(flush_d), .flush_e(flush_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_unit #(.FWD_DEPTH(3), .LOAD_STAGE(3), .CNT_W(2)) dut_l (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_dst(id_dst), .id_we(id_we), .id_is_load(id_is_load), .br_taken_e(br_taken_e),
        .mem_stall(mem_stall), .fwd_sel(l_fwd_sel), .stall_fd(l_stall_fd), .freeze(l_freeze),
        .flush_d(l_flush_d), .flush_e(l_flush_e), .stall_cnt(l_stall_cnt), .flush_cnt(l_flush_cnt)
    );

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] dst, input logic we, input logic ld);
        id_valid = v;
        id_src = {s1, s0};
        id_src_used = used;
        id_dst = dst;
        id_we = we;
        id_is_load = ld;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        br_taken_e = 1'b0;
        mem_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1, 3, 4, 2'b11, 5, 1, 1);
        br_taken_e = 1'b1;
        mem_stall = 1'b1;
        tick();
        tick();
        checks++;
        if ({freeze, flush_d, flush_e, stall_fd} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {freeze, flush_d, flush_e, stall_fd});
        end
        checks++;
        if (fwd_sel !== 4'd0 || l_fwd_sel !== 4'd0) begin
            failures++;
            $display("FAIL reset_fwd got=%h/%h exp=0/0", fwd_sel, l_fwd_sel);
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cnt, flush_cnt);
        end
        do_reset();
    endtask

    task automatic test_alu_fwd;
        do_reset();
        drive(1, 0, 0, 2'b00, 3, 1, 0);
        tick();
        drive(1, 3, 1, 2'b11, 7, 1, 0);
        tick();
        checks++;
        if (fwd_sel !== 4'b0001) begin
            failures++;
            $display("FAIL alu_fwd_m got=%b exp=0001", fwd_sel);
        end
        drive(1, 2, 3, 2'b11, 8, 1, 0);
        tick();
        checks++;
        if (fwd_sel !== 4'b1000) begin
            failures++;
            $display("FAIL alu_fwd_w got=%b exp=1000", fwd_sel);
        end
        drive(1, 3, 0, 2'b01, 9, 1, 0);
        tick();
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("FAIL alu_fwd_rf got=%b exp=0000", fwd_sel);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_load_use;
        do_reset();
        drive(1, 0, 0, 2'b00, 4, 1, 1);
        tick();
        drive(1, 4, 4, 2'b11, 5, 1, 0);
        #1;
        checks++;
        if ({stall_fd, flush_e, flush_d} !== 3'b110) begin
            failures++;
            $display("FAIL lu_stall got=%b exp=110", {stall_fd, flush_e, flush_d});
        end
        tick();
        checks++;
        if ({stall_fd, flush_e} !== 2'b00) begin
            failures++;
            $display("FAIL lu_release got=%b exp=00", {stall_fd, flush_e});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (fwd_sel !== 4'b1010) begin
            failures++;
            $display("FAIL lu_fwd got=%b exp=1010", fwd_sel);
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL lu_cnt got=%0d exp=1", stall_cnt);
        end
    endtask

    task automatic test_long_load;
        do_reset();
        drive(1, 0, 0, 2'b00, 4, 1, 1);
        tick();
        drive(1, 4, 4, 2'b11, 5, 1, 0);
        #1;
        checks++;
        if (l_stall_fd !== 1'b1) begin
            failures++;
            $display("FAIL long_stall1 got=%b exp=1", l_stall_fd);
        end
        tick();
        checks++;
        if (l_stall_fd !== 1'b1) begin
            failures++;
            $display("FAIL long_stall2 got=%b exp=1", l_stall_fd);
        end
        tick();
        checks++;
        if (l_stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL long_stall3 got=%b exp=0", l_stall_fd);
        end
        tick();
        checks++;
        if (l_fwd_sel !== 4'b1111) begin
            failures++;
            $display("FAIL long_fwd got=%b exp=1111", l_fwd_sel);
        end
        checks++;
        if (l_stall_cnt !== 2'd2) begin
            failures++;
            $display("FAIL long_cnt got=%0d exp=2", l_stall_cnt);
        end
        drive(1, 0, 0, 2'b00, 4, 1, 1);
        tick();
        drive(1, 4, 4, 2'b11, 5, 1, 0);
        tick();
        tick();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (l_stall_cnt !== 2'd3) begin
            failures++;
            $display("FAIL long_sat got=%0d exp=3", l_stall_cnt);
        end
    endtask

    task automatic test_reg0_shadow;
        do_reset();
        drive(1, 0, 0, 2'b00, 0, 1, 1);
        tick();
        drive(1, 0, 0, 2'b01, 5, 1, 0);
        #1;
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL r0_stall got=%b exp=0", stall_fd);
        end
        tick();
        checks++;
        if (fwd_sel !== 4'b0000) begin
            failures++;
            $display("FAIL r0_fwd got=%b exp=0000", fwd_sel);
        end
        do_reset();
        drive(1, 0, 0, 2'b00, 6, 1, 1);
        tick();
        drive(1, 0, 0, 2'b00, 6, 1, 0);
        tick();
        drive(1, 6, 0, 2'b01, 7, 1, 0);
        #1;
        checks++;
        if (stall_fd !== 1'b0) begin
            failures++;
            $display("FAIL shadow_stall got=%b exp=0", stall_fd);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (fwd_sel !== 4'b0001) begin
            failures++;
            $display("FAIL shadow_fwd got=%b exp=0001", fwd_sel);
        end
    endtask

    task automatic test_branch_load_use;
        do_reset();
        drive(1, 0, 0, 2'b00, 4, 1, 1);
        tick();
        drive(1, 4, 4, 2'b11, 5, 1, 0);
        br_taken_e = 1'b1;
        #1;
        checks++;
        if ({flush_d, flush_e, stall_fd} !== 3'b110) begin
            failures++;
            $display("FAIL br_lu got=%b exp=110", {flush_d, flush_e, stall_fd});
        end
        tick();
        br_taken_e = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            failures++;
            $display("FAIL br_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_freeze_reset;
        do_reset();
        br_taken_e = 1'b1;
        tick();
        br_taken_e = 1'b0;
        drive(1, 0, 0, 2'b00, 3, 1, 0);
        tick();
        drive(1, 3, 0, 2'b01, 7, 1, 0);
        tick();
        checks++;
        if (fwd_sel !== 4'b0001) begin
            failures++;
            $display("FAIL frz_pre got=%b exp=0001", fwd_sel);
        end
        mem_stall = 1'b1;
        br_taken_e = 1'b1;
        drive(1, 7, 7, 2'b11, 8, 1, 0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({freeze, flush_d, flush_e, stall_fd} !== 4'b1000 || fwd_sel !== 4'b0001 ||
                flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
                failures++;
                $display("FAIL frz_hold cyc=%0d got=%b fwd=%b fc=%0d sc=%0d exp=1000 fwd=0001 fc=1 sc=0",
                         c, {freeze, flush_d, flush_e, stall_fd}, fwd_sel, flush_cnt, stall_cnt);
            end
            tick();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({freeze, flush_d, flush_e} !== 3'b000 || fwd_sel !== 4'b0000 || flush_cnt !== 16'd0) begin
            failures++;
            $display("FAIL frz_reset got=%b fwd=%b fc=%0d exp=000 fwd=0000 fc=0",
                     {freeze, flush_d, flush_e}, fwd_sel, flush_cnt);
        end
        mem_stall = 1'b0;
        br_taken_e = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        br_taken_e = 1'b0;
        mem_stall = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_long_load();
        test_reg0_shadow();
        test_branch_load_use();
        test_freeze_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the 5-stage pipelined datapath. It tracks destination-register state of in-flight instructions from E through W, and produces:
- forwarding selects for the two E-stage source operands;
- load-use and multi-cycle-load stalls;
- branch-taken flushes;
- a global memory freeze.

It sits beside the datapath, drives the enable/clear pins of its stage registers, and keeps saturating stall/flush event counters.

## Interface
Parameters:
- REG_W, 5, register-id width
- N_SRC, 2, source operands per instruction
- FWD_DEPTH, 2, forwarding stages after E (1=M … FWD_DEPTH=W)
- LOAD_STAGE, 2, first stage index holding load data; 1 ≤ LOAD_STAGE ≤ FWD_DEPTH
- CNT_W, 16, event-counter width
- SEL_W is derived, not a parameter: SEL_W = $clog2(FWD_DEPTH+1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  D stage holds a real instruction
- id_src  in  N_SRC*REG_W  D-stage source register ids
- id_src_used  in  N_SRC  per-source "operand read" flag
- id_dst  in  REG_W  D-stage destination id
- id_we  in  1  D instruction writes a register
- id_is_load  in  1  D instruction is a load
- br_taken_e  in  1  branch in E resolved taken
- mem_stall  in  1  data memory not ready
- fwd_sel  out  N_SRC*SEL_W  per E source: 0=register file, k=stage k
- stall_fd  out  1  hold F and D registers
- freeze  out  1  hold every pipeline register
- flush_d  out  1  clear D register
- flush_e  out  1  insert bubble into E
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  branch flush events, saturating

## Operation
- **Scoreboard.** Entries 0..FWD_DEPTH (0=E, FWD_DEPTH=W), each holding {valid, dst, we, is_load}. E also holds e_src[N_SRC] and e_used[N_SRC].
- **Advance.** On a clock edge with freeze=0:
  - entry k+1 ← entry k; entry FWD_DEPTH retires;
  - entry 0 ← D info if id_valid & !flush_e, else a bubble (valid=0).
- **Hold.** freeze=1: all entries hold.
- **Forwarding.** fwd_sel[i] = the smallest k in 1..FWD_DEPTH with:
  - entry k valid & we & dst==e_src[i] & dst≠0 & e_used[i];
  - and, if entry k is a load, k ≥ LOAD_STAGE.
  - Otherwise fwd_sel[i] = 0.
  - This is purely a function of registered state.
- **Load-use hazard.** Asserted if, for some source i with id_src_used[i] & id_src[i]≠0, the youngest entry j (0..FWD_DEPTH) with valid & we & dst==id_src[i] is a load with j ≤ LOAD_STAGE−2. Older matches are shadowed by younger ones.
- **Outputs:**
  - freeze = mem_stall.
  - branch = br_taken_e & !mem_stall.
  - flush_d = branch.
  - flush_e = branch | (load-use & !mem_stall & id_valid).
  - stall_fd = load-use & id_valid & !branch & !mem_stall.
  - Priority: mem_stall > branch > load-use.
- **Counters.**
  - stall_cnt +1 on each edge where stall_fd=1.
  - flush_cnt +1 on each edge where flush_d=1.
  - Both saturate at 2^CNT_W−1 and hold there; no wrap.
- **Register 0.** Register 0 is never a hazard source or a forwarding target.

## Timing
- **Reset.** While rst_n=0, asynchronously:
  - all entries invalid, e_src=0, counters 0;
  - all outputs 0 (outputs are gated by rst_n).
  - Reset asserted mid-stall or mid-freeze clears state immediately.
  - The first edge after release starts a normal advance.
- **Output timing.**
  - fwd_sel is valid from the start of the cycle the consumer occupies E; zero combinational path from inputs.
  - stall_fd, flush_* and freeze are combinational from the inputs and state in the same cycle. The datapath applies them at the next edge.
- **Stall length.** A load-use stall lasts LOAD_STAGE−1−j cycles for a producer at entry j. The default configuration gives exactly 1 cycle.
- **mem_stall during a load-use stall.** The stall cycle count is extended, not consumed; stall_cnt does not increment while freeze=1.
- **Branch and load-use together.** Branch wins: the D instruction is squashed, stall_fd=0, and stall_cnt is unchanged.

## Test plan
- **ALU forwarding.** add $3 then sub using $3 (rs) → fwd_sel[0]=1 while sub is in E. A consumer two instructions later → fwd_sel=2. A consumer three later → 0.
- **Load-use, default config.** lw $4 then add $5,$4,$4 → stall_fd=1 and flush_e=1 for exactly 1 cycle; then fwd_sel[0]=fwd_sel[1]=2; stall_cnt=1.
- **Long load (FWD_DEPTH=3, LOAD_STAGE=3).** lw $4 followed by consumer → 2 stall cycles, then fwd_sel=3; stall_cnt=2.
- **Register 0 and shadowing.**
  - lw $0 then use of $0 → no stall, fwd_sel=0.
  - lw $6, add $6, then use of $6 → no stall, fwd_sel=1.
- **Branch during load-use.** br_taken_e=1 in the same cycle as a load-use → flush_d=1, flush_e=1, stall_fd=0; flush_cnt=1, stall_cnt=0.
- **Freeze and reset.**
  - mem_stall=1 for 3 cycles mid-forwarding → freeze=1, fwd_sel constant, counters unchanged.
  - rst_n pulled low during freeze → all outputs 0 immediately.
  - With stall_cnt preloaded to 0xFFFF, a further stall leaves it at 0xFFFF.
